i2c_target: RTL and testbench
=============================

// Module: i2c_target
// PURPOSE
//  Fixed-address I2C target (slave); the responder to the team's I2C master on the same sda/scl wires.
//  Oversamples the bus on clk, decodes START, STOP and address+R/W, and ACKs its own address.
//  Writes: delivers received bytes on rx_*. Reads: shifts out bytes supplied on tx_*.
//  Sits between the pads and a register-file/FIFO client; clk must be >= 8x the scl rate.
// PARAMETERS
//  ADDR         7'h42  7-bit target address; matched MSB-first. General call is not supported.
//  SYNC_STAGES  2      flops in each sda/scl input synchronizer (>=2).
// PORTS
//  clk        in     1  system clock; all logic on posedge.
//  rst        in     1  asynchronous, active-high reset.
//  sda        inout  1  open-drain data; driven 0 or released (z), never driven 1.
//  scl        inout  1  open-drain clock; only driven low when I2C_STRETCH_EN is defined.
//  rx_data    out    8  last byte written by the master.
//  rx_valid   out    1  one-clk pulse; rx_data is new.
//  tx_data    in     8  next byte to return on a read.
//  tx_valid   in     1  tx_data holds a valid byte.
//  tx_ready   out    1  one-clk pulse; tx_data was loaded into the shifter.
//  busy       out    1  high from a detected START until STOP or an address mismatch.
//  rw         out    1  R/W bit of the current transfer (1 = read); valid while busy.
// BEHAVIOUR
//  Reset: sda/scl released, rx_data=0, rx_valid=0, tx_ready=0, busy=0, rw=0, state IDLE.
//  Input path: SYNC_STAGES-flop sync, then edge detect. Every bus event is seen SYNC_STAGES+1 clk late.
//  START = sda fall while scl high; STOP = sda rise while scl high. Both act in every state:
//   START (incl. repeated) -> ADDR with bit count 7; STOP -> IDLE with sda released.
//  Bits are sampled on scl rise and driven/changed on scl fall.
//  States:
//   IDLE  -> ADDR on START.
//   ADDR  shift 8 bits. On match -> AACK, rw latched, busy=1. On mismatch -> WAIT_STOP, busy=0, sda never driven.
//   AACK  pull sda low from the next scl fall to the following scl fall.
//         Then -> RDATA if rw=1, otherwise -> WDATA.
//   WDATA shift 8 bits. rx_data updates and rx_valid pulses 1 clk after the 8th rise.
//         Then -> WACK.
//   WACK  ACK as in AACK, always; then -> WDATA.
//   RDATA tx_data loads at the scl fall ending the preceding ACK; tx_ready pulses that clk.
//         Drive ~bit as sda enable, MSB first; release after the 8th bit. Then -> RACK.
//   RACK  sample sda on the 9th rise. 0 (ACK) -> RDATA. 1 (NACK) -> WAIT_STOP.
//   WAIT_STOP  sda released; wait for STOP/START.
//  Underrun: if tx_valid=0 at the load point (no stretch), the shifter loads 8'hFF (bus stays released).
//  rx_valid and tx_ready never assert in the same clk.
//  Reset mid-transfer releases sda/scl combinationally; the next valid event is a START.
// CONFIGURATION
//  I2C_STRETCH_EN defined: at an RDATA load point with tx_valid=0, hold scl low.
//   Release scl 1 clk after tx_valid rises; load tx_data and pulse tx_ready that clk.
//  I2C_STRETCH_EN undefined: scl is an input only (tied z); underrun sends 8'hFF.
// STRUCTURE
//  i2c_pkg: state encodings (IDLE..WAIT_STOP), I2C_ACK=1'b0, I2C_NACK=1'b1, bit-count width.
//  Shared with the master.
//  Sub-module i2c_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulses.
//  Instanced twice, for scl and for sda.
// TESTING
//  1 Write 0x42<<1|0, data 0xA5, STOP -> ACK on both 9th bits; rx_data=0xA5; one rx_valid; busy 1->0.
//  2 Address 0x43 write -> sda never driven (NACK), busy low, rx_valid never pulses, back to IDLE after STOP.
//  3 Read 0x42, tx_data=0x3C, tx_valid=1; master ACK then NACK -> bus bytes 0x3C,0x3C.
//    tx_ready pulses twice; WAIT_STOP; then IDLE.
//  4 Write 0x11, repeated START, read -> rx_data=0x11, then rw=1, AACK, tx byte shifted; no STOP in between.
//  5 Assert rst mid-data-byte while target drives sda low -> sda z at once; outputs at reset values.
//    Next full write succeeds.
//  6 Read with tx_valid=0: STRETCH_EN scl held low until tx_valid, then 0x3C sent; without it 0xFF sent.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings, ACK/NACK levels and bit-counter sizing.
package i2c_pkg;

  localparam int unsigned BIT_CNT_W = 3;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = BIT_CNT_W'(7);

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_AACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_RACK,
    ST_WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_if.sv
// Client-side byte interface of the I2C target: received bytes out, bytes to send in, transfer status.
interface i2c_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       rw;

  modport slave (
    output rx_data, rx_valid, tx_ready, busy, rw,
    input  tx_data, tx_valid
  );

  modport master (
    input  rx_data, rx_valid, tx_ready, busy, rw,
    output tx_data, tx_valid
  );

endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one bus line with registered level and rise/fall pulses.
module i2c_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Reset to the released (high) level so a quiet bus produces no edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
         level  <= 1'b1;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         level  <= sync_q[SYNC_STAGES-1];
         rise   <= sync_q[SYNC_STAGES-1] & ~level;
         fall   <= ~sync_q[SYNC_STAGES-1] & level;
      end
   end

endmodule

// File: rtl/i2c_target.sv
// Fixed-address I2C target: decodes START/STOP/address, delivers written bytes, shifts out read bytes.
// Define I2C_STRETCH_EN to hold scl low on a read underrun instead of sending 8'hFF.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0]  ADDR        = 7'h42,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   inout  wire  sda,
   inout  wire  scl,
   i2c_if.slave bus
);

`ifdef I2C_STRETCH_EN
   localparam bit STRETCH = 1'b1;
`else
   localparam bit STRETCH = 1'b0;
`endif

   i2c_state_e           state_q, state_d;
   logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]           shreg_q, shreg_d, rx_data_q, rx_data_d, load_byte_c;
   logic                 ack_on_q, ack_on_d, load_pend_q, load_pend_d, stall_q, stall_d;
   logic                 sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
   logic                 rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
   logic                 busy_q, busy_d, rw_q, rw_d;
   logic                 scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
   logic                 start_c, stop_c, load_pt_c, load_go_c;

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
      .clk(clk), .rst(rst), .din(scl), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
      .clk(clk), .rst(rst), .din(sda), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
   );

   assign start_c     = sda_fall & scl_lvl;
   assign stop_c      = sda_rise & scl_lvl;
   assign load_byte_c = bus.tx_valid ? bus.tx_data : 8'hFF;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // START and STOP override every state.
   always_comb begin
      state_d = state_q;
      if (start_c) begin
         state_d = ST_ADDR;
      end else if (stop_c) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_ADDR:  if (scl_rise && cnt_q == '0)
                         state_d = (shreg_q[6:0] == ADDR) ? ST_AACK : ST_WAIT_STOP;
            ST_AACK:  if (scl_fall && ack_on_q) state_d = rw_q ? ST_RDATA : ST_WDATA;
            ST_WDATA: if (scl_rise && cnt_q == '0) state_d = ST_WACK;
            ST_WACK:  if (scl_fall && ack_on_q) state_d = ST_WDATA;
            ST_RDATA: if (scl_fall && !stall_q && !load_pend_q && cnt_q == '0) state_d = ST_RACK;
            ST_RACK:  if (scl_rise) state_d = (sda_lvl == I2C_ACK) ? ST_RDATA : ST_WAIT_STOP;
            default:  ;
         endcase
      end
   end

   always_comb begin
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      ack_on_d    = ack_on_q;
      load_pend_d = load_pend_q;
      stall_d     = stall_q;
      sda_oe_d    = sda_oe_q;
      scl_oe_d    = scl_oe_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      tx_ready_d  = 1'b0;
      busy_d      = busy_q;
      rw_d        = rw_q;
      load_pt_c   = 1'b0;
      load_go_c   = 1'b0;
      if (start_c || stop_c) begin
         cnt_d       = BIT_CNT_MAX;
         ack_on_d    = 1'b0;
         load_pend_d = 1'b0;
         stall_d     = 1'b0;
         sda_oe_d    = 1'b0;
         scl_oe_d    = 1'b0;
         busy_d      = start_c;
      end else begin
         case (state_q)
            ST_ADDR: if (scl_rise) begin
               shreg_d = {shreg_q[6:0], sda_lvl};
               cnt_d   = cnt_q - BIT_CNT_W'(1);
               if (cnt_q == '0) begin
                  ack_on_d = 1'b0;
                  if (shreg_q[6:0] == ADDR) begin
                     rw_d   = sda_lvl;
                     busy_d = 1'b1;
                  end else begin
                     busy_d = 1'b0;
                  end
               end
            end
            // ACK window: first fall starts driving low, second fall releases.
            ST_AACK, ST_WACK: if (scl_fall) begin
               if (!ack_on_q) begin
                  sda_oe_d = 1'b1;
                  ack_on_d = 1'b1;
               end else begin
                  sda_oe_d  = 1'b0;
                  ack_on_d  = 1'b0;
                  cnt_d     = BIT_CNT_MAX;
                  load_pt_c = (state_q == ST_AACK) && rw_q;
               end
            end
            ST_WDATA: if (scl_rise) begin
               shreg_d = {shreg_q[6:0], sda_lvl};
               cnt_d   = cnt_q - BIT_CNT_W'(1);
               if (cnt_q == '0) begin
                  rx_data_d  = {shreg_q[6:0], sda_lvl};
                  rx_valid_d = 1'b1;
               end
            end
            ST_RDATA: begin
               if (stall_q) begin
                  if (bus.tx_valid) begin
                     scl_oe_d  = 1'b0;
                     stall_d   = 1'b0;
                     load_go_c = 1'b1;
                  end
               end else if (scl_fall) begin
                  if (load_pend_q) begin
                     load_pt_c = 1'b1;
                  end else if (cnt_q == '0) begin
                     sda_oe_d = 1'b0;
                  end else begin
                     cnt_d    = cnt_q - BIT_CNT_W'(1);
                     shreg_d  = {shreg_q[6:0], 1'b1};
                     sda_oe_d = ~shreg_q[6];
                  end
               end
            end
            ST_RACK: if (scl_rise && sda_lvl == I2C_ACK) load_pend_d = 1'b1;
            default: ;
         endcase
         // Load point: take tx_data (or 8'hFF on underrun), or stall scl when stretching is enabled.
         if (load_pt_c) begin
            if (bus.tx_valid || !STRETCH) begin
               load_go_c = 1'b1;
            end else begin
               scl_oe_d    = 1'b1;
               stall_d     = 1'b1;
               load_pend_d = 1'b0;
            end
         end
         if (load_go_c) begin
            shreg_d     = load_byte_c;
            cnt_d       = BIT_CNT_MAX;
            sda_oe_d    = ~load_byte_c[7];
            tx_ready_d  = bus.tx_valid;
            load_pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         shreg_q     <= '0;
         ack_on_q    <= 1'b0;
         load_pend_q <= 1'b0;
         stall_q     <= 1'b0;
         sda_oe_q    <= 1'b0;
         scl_oe_q    <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         tx_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         rw_q        <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         ack_on_q    <= ack_on_d;
         load_pend_q <= load_pend_d;
         stall_q     <= stall_d;
         sda_oe_q    <= sda_oe_d;
         scl_oe_q    <= scl_oe_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         tx_ready_q  <= tx_ready_d;
         busy_q      <= busy_d;
         rw_q        <= rw_d;
      end
   end

   // Open-drain pads: only ever pull low, released immediately while in reset.
   assign sda = (sda_oe_q && !rst) ? 1'b0 : 1'bz;
   assign scl = (STRETCH && scl_oe_q && !rst) ? 1'b0 : 1'bz;

   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.tx_ready = tx_ready_q;
   assign bus.busy     = busy_q;
   assign bus.rw       = rw_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged open-drain master, scoreboard on rx bytes, directed transfers.
module tb_i2c_target;
   import i2c_pkg::*;

   localparam int unsigned QTR      = 10;
   localparam int unsigned WAIT_MAX = 2000;
`ifdef I2C_STRETCH_EN
   localparam logic [7:0] T6_EXP  = 8'h3C;
   localparam logic       STRETCH = 1'b1;
`else
   localparam logic [7:0] T6_EXP  = 8'hFF;
   localparam logic       STRETCH = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wire  sda, scl;
   logic m_sda_low, m_scl_low;
   assign sda = m_sda_low ? 1'b0 : 1'bz;
   assign scl = m_scl_low ? 1'b0 : 1'bz;
   pullup (sda);
   pullup (scl);

   i2c_if cif ();

   i2c_target #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sda(sda), .scl(scl), .bus(cif)
   );

   int n_checks, n_errors, mon_checks, mon_errors;
   int txr_cnt, tgt_drive_cnt, max_wait;
   logic [7:0] exp_q[$];

   // Scoreboard monitor: every rx_valid pops one expected byte.
   always @(negedge clk) begin
      if (!rst) begin
         if (cif.tx_ready) begin
            txr_cnt++;
            mon_checks++;
            if (cif.rx_valid) begin
               mon_errors++;
               $display("FAIL rx_tx_excl: rx_valid=1 tx_ready=1 in same clk, required not both");
            end
         end
         if (cif.rx_valid) begin
            mon_checks++;
            if (exp_q.size() == 0) begin
               mon_errors++;
               $display("FAIL rx_unexpected: got rx_data 0x%0h, required no rx_valid", cif.rx_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (cif.rx_data !== e) begin
                  mon_errors++;
                  $display("FAIL rx_data: got 0x%0h required 0x%0h", cif.rx_data, e);
               end
            end
         end
         if (sda === 1'b0 && !m_sda_low) tgt_drive_cnt++;
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded 60000 clks, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic qwait();
      repeat (QTR) @(negedge clk);
   endtask

   task automatic wait_scl_high();
      int n;
      n = 0;
      while (scl !== 1'b1 && n < int'(WAIT_MAX)) begin
         @(negedge clk);
         n++;
      end
      if (n > max_wait) max_wait = n;
      if (n >= int'(WAIT_MAX)) begin
         n_checks++;
         n_errors++;
         $display("FAIL scl_timeout: scl low for %0d clks, required release within %0d", n, WAIT_MAX);
      end
   endtask

   task automatic bus_start();
      m_sda_low = 1'b0; qwait();
      m_scl_low = 1'b0; wait_scl_high(); qwait();
      m_sda_low = 1'b1; qwait();
      m_scl_low = 1'b1; qwait();
   endtask

   task automatic bus_stop();
      m_sda_low = 1'b1; qwait();
      m_scl_low = 1'b0; wait_scl_high(); qwait();
      m_sda_low = 1'b0; qwait();
   endtask

   task automatic write_bit(input logic b);
      m_sda_low = ~b; qwait();
      m_scl_low = 1'b0; wait_scl_high(); qwait(); qwait();
      m_scl_low = 1'b1; qwait();
   endtask

   task automatic read_bit(output logic b);
      m_sda_low = 1'b0; qwait();
      m_scl_low = 1'b0; wait_scl_high(); qwait();
      b = sda;
      m_scl_low = 1'b1; qwait();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
   endtask

   logic       ack;
   logic [7:0] rb;
   int         snap;

   initial begin
      rst = 1'b1; m_sda_low = 1'b0; m_scl_low = 1'b0;
      cif.tx_data = 8'h00; cif.tx_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_busy", 32'(cif.busy), 0);
      chk("rst_rx_valid", 32'(cif.rx_valid), 0);
      chk("rst_tx_ready", 32'(cif.tx_ready), 0);
      chk("rst_rx_data", 32'(cif.rx_data), 0);
      chk("rst_rw", 32'(cif.rw), 0);
      chk("rst_sda", 32'(sda), 1);
      chk("rst_scl", 32'(scl), 1);
      rst = 1'b0;
      qwait();

      // 1: write 0xA5 to 0x42
      exp_q.push_back(8'hA5);
      snap = txr_cnt;
      bus_start();
      chk("t1_busy_start", 32'(cif.busy), 1);
      write_byte(8'h84, ack);
      chk("t1_addr_ack", 32'(ack), 0);
      chk("t1_busy", 32'(cif.busy), 1);
      chk("t1_rw", 32'(cif.rw), 0);
      write_byte(8'hA5, ack);
      chk("t1_data_ack", 32'(ack), 0);
      bus_stop(); qwait();
      chk("t1_rx_data", 32'(cif.rx_data), 32'h A5);
      chk("t1_busy_end", 32'(cif.busy), 0);
      chk("t1_tx_ready_cnt", 32'(txr_cnt - snap), 0);

      // 2: wrong address 0x43, target must stay off the bus
      snap = tgt_drive_cnt;
      bus_start();
      write_byte(8'h86, ack);
      chk("t2_addr_nack", 32'(ack), 1);
      chk("t2_busy", 32'(cif.busy), 0);
      write_byte(8'h55, ack);
      chk("t2_data_nack", 32'(ack), 1);
      bus_stop(); qwait();
      chk("t2_sda_driven", 32'(tgt_drive_cnt - snap), 0);

      // 3: read 0x42 twice, master ACK then NACK
      cif.tx_data = 8'h3C; cif.tx_valid = 1'b1;
      snap = txr_cnt;
      bus_start();
      write_byte(8'h85, ack);
      chk("t3_addr_ack", 32'(ack), 0);
      chk("t3_rw", 32'(cif.rw), 1);
      read_byte(rb);
      chk("t3_byte0", 32'(rb), 32'h3C);
      write_bit(I2C_ACK);
      read_byte(rb);
      chk("t3_byte1", 32'(rb), 32'h3C);
      write_bit(I2C_NACK);
      chk("t3_tx_ready_cnt", 32'(txr_cnt - snap), 2);
      bus_stop(); qwait();
      chk("t3_busy_end", 32'(cif.busy), 0);

      // 4: write 0x11, repeated START, read
      exp_q.push_back(8'h11);
      snap = txr_cnt;
      bus_start();
      write_byte(8'h84, ack);
      chk("t4_waddr_ack", 32'(ack), 0);
      write_byte(8'h11, ack);
      chk("t4_wdata_ack", 32'(ack), 0);
      chk("t4_rw_write", 32'(cif.rw), 0);
      bus_start();
      chk("t4_rx_data", 32'(cif.rx_data), 32'h11);
      write_byte(8'h85, ack);
      chk("t4_raddr_ack", 32'(ack), 0);
      chk("t4_rw_read", 32'(cif.rw), 1);
      chk("t4_busy", 32'(cif.busy), 1);
      read_byte(rb);
      chk("t4_rbyte", 32'(rb), 32'h3C);
      write_bit(I2C_NACK);
      chk("t4_tx_ready_cnt", 32'(txr_cnt - snap), 1);
      bus_stop(); qwait();

      // 5: reset while the target drives bit 7 (0) of a read byte
      bus_start();
      write_byte(8'h85, ack);
      chk("t5_addr_ack", 32'(ack), 0);
      chk("t5_tgt_drive", 32'(sda), 0);
      rst = 1'b1;
      #1;
      chk("t5_sda_released", 32'(sda), 1);
      chk("t5_busy", 32'(cif.busy), 0);
      chk("t5_rx_data", 32'(cif.rx_data), 0);
      chk("t5_rw", 32'(cif.rw), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      qwait();
      exp_q.push_back(8'h77);
      bus_start();
      write_byte(8'h84, ack);
      chk("t5_post_addr_ack", 32'(ack), 0);
      write_byte(8'h77, ack);
      chk("t5_post_data_ack", 32'(ack), 0);
      bus_stop(); qwait();
      chk("t5_post_rx_data", 32'(cif.rx_data), 32'h77);

      // 6: read with no tx data available at the load point
      cif.tx_valid = 1'b0;
      bus_start();
      write_byte(8'h85, ack);
      chk("t6_addr_ack", 32'(ack), 0);
      max_wait = 0;
      fork
         read_byte(rb);
         begin
            repeat (300) @(negedge clk);
            cif.tx_data  = 8'h3C;
            cif.tx_valid = 1'b1;
         end
      join
      chk("t6_byte", 32'(rb), 32'(T6_EXP));
      chk("t6_stretched", 32'(max_wait > 100), 32'(STRETCH));
      write_bit(I2C_NACK);
      bus_stop(); qwait();
      chk("t6_busy_end", 32'(cif.busy), 0);

      repeat (20) @(negedge clk);
      chk("exp_q_empty", 32'(exp_q.size()), 0);
      n_checks += mon_checks;
      n_errors += mon_errors;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
